// File: rtl/my_isolation_pkg.sv
// Shared types and defaults for the operand-isolation sequencer.
// State encoding, default timing constants and a counter-load helper.
package my_isolation_pkg;

   typedef enum logic [1:0] {
      ISO_ST_ISOLATED = 2'b00,
      ISO_ST_WAKE     = 2'b01,
      ISO_ST_ACTIVE   = 2'b10
   } iso_state_e;

   localparam int DEF_NUM_UNITS    = 4;
   localparam int DEF_WAKE_CYCLES  = 2;
   localparam int DEF_IDLE_TIMEOUT = 16;
   localparam int DEF_CNT_WIDTH    = 5;

   // Clamp a counter load into [0, 2^width-1] so loads never wrap.
   function automatic int sat_load(input int value, input int width);
      int max_val;
      max_val = (1 << width) - 1;
      if (value < 0)
         return 0;
      else if (value > max_val)
         return max_val;
      else
         return value;
   endfunction

endpackage

// File: rtl/my_isolation_unit_fsm.sv
// One unit's isolation FSM: ISOLATED -> WAKE -> ACTIVE with a shared
// wake/idle counter. Ports: clk, rst_n, req, force_pass, force_iso,
// signal (gate enable), ready, is_isolated_nxt (next-state flag).
module my_isolation_unit_fsm
   import my_isolation_pkg::*;
#(
   parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic force_pass,
   input  logic force_iso,
   output logic signal,
   output logic ready,
   output logic is_isolated_nxt
);

   localparam logic [CNT_WIDTH-1:0] WAKE_LOAD =
      CNT_WIDTH'(sat_load(WAKE_CYCLES - 1, CNT_WIDTH));
   localparam logic [CNT_WIDTH-1:0] IDLE_LOAD =
      CNT_WIDTH'(sat_load(IDLE_TIMEOUT - 1, CNT_WIDTH));
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   iso_state_e           state;
   iso_state_e           state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (force_iso) begin
         state_nxt = ISO_ST_ISOLATED;
         cnt_nxt   = '0;
      end else if (force_pass) begin
         // Held at the full timeout so release restarts the countdown.
         state_nxt = ISO_ST_ACTIVE;
         cnt_nxt   = IDLE_LOAD;
      end else begin
         case (state)
            ISO_ST_ISOLATED: begin
               cnt_nxt = '0;
               if (req) begin
                  if (WAKE_CYCLES > 0) begin
                     state_nxt = ISO_ST_WAKE;
                     cnt_nxt   = WAKE_LOAD;
                  end else begin
                     state_nxt = ISO_ST_ACTIVE;
                     cnt_nxt   = IDLE_LOAD;
                  end
               end
            end
            ISO_ST_WAKE: begin
               // A started wake always completes, req is ignored here.
               if (cnt == '0) begin
                  state_nxt = ISO_ST_ACTIVE;
                  cnt_nxt   = IDLE_LOAD;
               end else begin
                  cnt_nxt = cnt - ONE;
               end
            end
            ISO_ST_ACTIVE: begin
               if (req) begin
                  cnt_nxt = IDLE_LOAD;
               end else if (cnt == '0) begin
                  state_nxt = ISO_ST_ISOLATED;
               end else begin
                  cnt_nxt = cnt - ONE;
               end
            end
            default: begin
               state_nxt = ISO_ST_ISOLATED;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign is_isolated_nxt = (state_nxt == ISO_ST_ISOLATED);

   // Outputs decoded from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ISO_ST_ISOLATED;
         cnt    <= '0;
         signal <= 1'b0;
         ready  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         signal <= (state_nxt == ISO_ST_WAKE) ||
                   (state_nxt == ISO_ST_ACTIVE);
         ready  <= (state_nxt == ISO_ST_ACTIVE);
      end
   end

endmodule

// File: rtl/my_isolation_ctrl.sv
// Per-unit operand-isolation sequencer top: one FSM per unit plus the
// global force fan-out and the registered all-isolated flag.
// Ports: iClk, iReset_n, iUnit_Req, iForce_Pass, iForce_Isolate,
// oIsolation_Signal, oUnit_Ready, oAll_Isolated.
module my_isolation_ctrl
   import my_isolation_pkg::*;
#(
   parameter int NUM_UNITS    = DEF_NUM_UNITS,
   parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic                 iClk,
   input  logic                 iReset_n,
   input  logic [NUM_UNITS-1:0] iUnit_Req,
   input  logic                 iForce_Pass,
   input  logic                 iForce_Isolate,
   output logic [NUM_UNITS-1:0] oIsolation_Signal,
   output logic [NUM_UNITS-1:0] oUnit_Ready,
   output logic                 oAll_Isolated
);

   logic [NUM_UNITS-1:0] iso_nxt;

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
      my_isolation_unit_fsm #(
         .WAKE_CYCLES  (WAKE_CYCLES),
         .IDLE_TIMEOUT (IDLE_TIMEOUT),
         .CNT_WIDTH    (CNT_WIDTH)
      ) u_fsm (
         .clk             (iClk),
         .rst_n           (iReset_n),
         .req             (iUnit_Req[u]),
         .force_pass      (iForce_Pass),
         .force_iso       (iForce_Isolate),
         .signal          (oIsolation_Signal[u]),
         .ready           (oUnit_Ready[u]),
         .is_isolated_nxt (iso_nxt[u])
      );
   end

   // Registered from next states so it tracks the unit outputs.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n)
         oAll_Isolated <= 1'b1;
      else
         oAll_Isolated <= &iso_nxt;
   end

endmodule

// File: tb/tb_my_isolation_ctrl.sv
// Directed self-checking bench for my_isolation_ctrl (defaults:
// 4 units, wake 2, idle timeout 16).
module tb_my_isolation_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       fpass;
   logic       fiso;
   logic [3:0] sig;
   logic [3:0] rdy;
   logic       alli;

   int checks = 0;
   int errors = 0;

   my_isolation_ctrl dut (
      .iClk              (clk),
      .iReset_n          (rst_n),
      .iUnit_Req         (req),
      .iForce_Pass       (fpass),
      .iForce_Isolate    (fiso),
      .oIsolation_Signal (sig),
      .oUnit_Ready       (rdy),
      .oAll_Isolated     (alli)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] s,
                      input logic [3:0] r, input logic a);
      checks++;
      assert ({sig, rdy, alli} === {s, r, a}) else begin
         errors++;
         $error("FAIL %s: observed sig=%b rdy=%b all=%b expected sig=%b rdy=%b all=%b",
                tag, sig, rdy, alli, s, r, a);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      req   = '0;
      fpass = 1'b0;
      fiso  = 1'b0;
      #3 rst_n = 1'b0;
      #1 chk("reset_async", 4'b0000, 4'b0000, 1'b1);
      tick(2);
      rst_n = 1'b1;
      tick(50);
      chk("idle_50", 4'b0000, 4'b0000, 1'b1);

      // wake latency on unit 1
      req = 4'b0010;
      tick(1);
      chk("wake_sig", 4'b0010, 4'b0000, 1'b0);
      tick(1);
      chk("wake_mid", 4'b0010, 4'b0000, 1'b0);
      tick(1);
      chk("wake_ready", 4'b0010, 4'b0010, 1'b0);

      // idle timeout: 16 idle samples close the gate
      req = 4'b0000;
      tick(15);
      chk("idle_15", 4'b0010, 4'b0010, 1'b0);
      tick(1);
      chk("idle_close", 4'b0000, 4'b0000, 1'b1);

      // request on the terminal cycle keeps the unit active
      req = 4'b0010;
      tick(3);
      chk("rewake", 4'b0010, 4'b0010, 1'b0);
      req = 4'b0000;
      tick(15);
      chk("pre_term", 4'b0010, 4'b0010, 1'b0);
      req = 4'b0010;
      tick(1);
      chk("term_req", 4'b0010, 4'b0010, 1'b0);
      req = 4'b0000;
      tick(15);
      chk("reload_15", 4'b0010, 4'b0010, 1'b0);
      tick(1);
      chk("reload_close", 4'b0000, 4'b0000, 1'b1);

      // force priority
      req = 4'b0101;
      tick(3);
      chk("units02", 4'b0101, 4'b0101, 1'b0);
      req = 4'b0000;
      fpass = 1'b1;
      fiso  = 1'b1;
      tick(1);
      chk("force_both", 4'b0000, 4'b0000, 1'b1);
      fiso = 1'b0;
      tick(1);
      chk("force_pass", 4'b1111, 4'b1111, 1'b0);
      tick(20);
      chk("pass_hold", 4'b1111, 4'b1111, 1'b0);
      fpass = 1'b0;
      tick(15);
      chk("pass_rel15", 4'b1111, 4'b1111, 1'b0);
      tick(1);
      chk("pass_close", 4'b0000, 4'b0000, 1'b1);

      // req dropped during wake
      req = 4'b1000;
      tick(1);
      req = 4'b0000;
      chk("drop_sig", 4'b1000, 4'b0000, 1'b0);
      tick(2);
      chk("drop_ready", 4'b1000, 4'b1000, 1'b0);
      tick(15);
      chk("drop_15", 4'b1000, 4'b1000, 1'b0);
      tick(1);
      chk("drop_close", 4'b0000, 4'b0000, 1'b1);

      // async reset while unit 2 wakes
      req = 4'b0100;
      tick(1);
      req = 4'b0000;
      chk("u2_wake", 4'b0100, 4'b0000, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk("mid_reset", 4'b0000, 4'b0000, 1'b1);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      chk("post_reset", 4'b0000, 4'b0000, 1'b1);
      req = 4'b0100;
      tick(1);
      chk("restart_sig", 4'b0100, 4'b0000, 1'b0);
      tick(1);
      chk("restart_mid", 4'b0100, 4'b0000, 1'b0);
      tick(1);
      chk("restart_rdy", 4'b0100, 4'b0100, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/my_isolation_ctrl.md
Name: my_isolation_ctrl

Overview:
- Per-unit operand-isolation sequencer for the functional units of a PE/CP datapath.
- Drives the isolation-enable input of each unit's isolation gate. Enable = 1 passes operands; enable = 0 forces them to zero.
- Opens the gate on demand, reports the unit ready after a fixed wake delay, and closes the gate after a programmable idle timeout to save switching power.
- Sits between the instruction decoder (per-unit requests) and the isolation gates.

Parameters:
- NUM_UNITS, 4: number of independently isolated functional units.
- WAKE_CYCLES, 2: cycles from gate-open to unit-ready. Range 0..2^CNT_WIDTH-1.
- IDLE_TIMEOUT, 16: consecutive idle cycles before the gate closes. Range 1..2^CNT_WIDTH.
- CNT_WIDTH, 5: width of the per-unit wake/idle counter.

Ports:
- iClk  input  1  system clock, rising edge
- iReset_n  input  1  asynchronous, active-low reset
- iUnit_Req  input  NUM_UNITS  bit u = unit u has an operation this cycle
- iForce_Pass  input  1  global override: all gates open, no timeout
- iForce_Isolate  input  1  global override: all gates closed; beats every other input
- oIsolation_Signal  output  NUM_UNITS  bit u = gate enable for unit u (1 = pass)
- oUnit_Ready  output  NUM_UNITS  bit u = unit u's operands valid and unit may issue
- oAll_Isolated  output  1  1 when every unit is in ISOLATED

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset (async assert, sync release):
  - every unit FSM in ISOLATED, counters 0;
  - oIsolation_Signal = 0, oUnit_Ready = 0, oAll_Isolated = 1.
- Each unit has its own FSM with states ISOLATED, WAKE, ACTIVE and a CNT_WIDTH-bit counter.
- ISOLATED: signal = 0, ready = 0.
  - req sampled 1 with WAKE_CYCLES > 0: go to WAKE, load counter = WAKE_CYCLES-1.
  - req sampled 1 with WAKE_CYCLES = 0: go straight to ACTIVE.
- WAKE: signal = 1, ready = 0.
  - Counter decrements each cycle; at counter = 0 go to ACTIVE and load the idle counter = IDLE_TIMEOUT-1.
  - Dropping req during WAKE does not abort the wake; the unit still reaches ACTIVE.
- ACTIVE: signal = 1, ready = 1.
  - req = 1 reloads the idle counter to IDLE_TIMEOUT-1.
  - req = 0 decrements the idle counter.
  - req = 0 with counter = 0 goes to ISOLATED.
  - A request on the terminal cycle wins: the unit stays ACTIVE and the counter reloads.
- Latency:
  - req first sampled at edge t in ISOLATED: signal = 1 from cycle t+1; ready = 1 from cycle t+1+WAKE_CYCLES.
  - After IDLE_TIMEOUT consecutive sampled req = 0 cycles in ACTIVE: signal and ready both 0 on the next cycle.
  - signal never deasserts while ready = 1. Both drop on the same edge.
- iForce_Isolate = 1: every unit goes to ISOLATED at the next edge regardless of state, req or iForce_Pass. Counters clear.
- iForce_Pass = 1 (and no isolate):
  - every unit goes to ACTIVE at the next edge, bypassing WAKE; idle counter held at IDLE_TIMEOUT-1.
  - On release, normal idle countdown resumes from the full timeout.
- Counters never wrap. Decrement only when nonzero; loads saturate to the counter width.
- oAll_Isolated = registered AND of (state == ISOLATED) over all units.
- Reset asserted mid-WAKE or mid-ACTIVE: immediate return to the reset values, asynchronously.
- Units are fully independent. Simultaneous requests from all units are allowed; there is no arbitration.

Decomposition:
- Shared package my_isolation_pkg:
  - state encoding constants ISO_ST_ISOLATED = 2'b00, ISO_ST_WAKE = 2'b01, ISO_ST_ACTIVE = 2'b10 (2'b11 illegal, recovers to ISOLATED);
  - default WAKE_CYCLES / IDLE_TIMEOUT constants.
- Sub-module my_isolation_unit_fsm:
  - one unit's FSM plus counter, outputs signal/ready/is_isolated;
  - instantiated NUM_UNITS times by a generate loop in the top;
  - the top adds only the force fan-out and the oAll_Isolated reduction register.

Test Plan:
- Reset: drive iReset_n = 0 mid-clock -> outputs go immediately to oIsolation_Signal = 4'b0000, oUnit_Ready = 4'b0000, oAll_Isolated = 1. Release, hold req = 0 for 50 cycles -> outputs unchanged.
- Wake latency (WAKE_CYCLES = 2): iUnit_Req[1] = 1 sampled at cycle 5 -> oIsolation_Signal[1] = 1 at cycle 6, oUnit_Ready[1] = 1 at cycle 8, oAll_Isolated = 0 at cycle 6. Other bits stay 0.
- Idle timeout (IDLE_TIMEOUT = 16): unit 1 ACTIVE, req low sampled at cycles 10..25 -> signal[1] = ready[1] = 0 at cycle 26. Repeat with req pulsed at cycle 25 -> unit stays ACTIVE, and closes at cycle 42 if req stays low from cycle 26 on.
- Force priority: units 0 and 2 ACTIVE, assert iForce_Pass and iForce_Isolate together at cycle 30 -> oIsolation_Signal = 4'b0000 at cycle 31. Drop isolate, keep pass -> 4'b1111 and ready = 4'b1111 next cycle, with no wake delay.
- Req drop during WAKE: req[3] high for one cycle only (cycle 40) -> signal[3] = 1 at 41, ready[3] = 1 at 43, closes after 16 idle cycles at cycle 59.
- Mid-operation reset: assert iReset_n = 0 while unit 2 is in WAKE -> asynchronous return to reset values. After release, a new req restarts the full WAKE_CYCLES delay.
